// File: rtl/fan_ctrl_pkg.sv
// ============================================================================
// Module   : fan_ctrl_pkg
// Purpose  : FSM state encodings and clog2 helper for the fan tach reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tach_glitch_filter.sv
// ============================================================================
// Module   : tach_glitch_filter
// Purpose  : Synchronises the raw tach line, rejects pulses shorter than
//            FILTER_TICKS enable ticks, and emits a rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tach_glitch_filter
    import fan_ctrl_pkg::*;
#(
    parameter int FILTER_TICKS = 4
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clk_en_i,
    input  logic tach_i,
    output logic edge_o
);

    localparam int c_FCNT_W = (clog2(FILTER_TICKS) < 1) ? 1 : clog2(FILTER_TICKS);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_filt;
    logic                r_filt_d;
    logic [c_FCNT_W-1:0] r_fcnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_filt   <= 1'b0;
            r_filt_d <= 1'b0;
            r_fcnt   <= '0;
        end else begin
            r_sync1  <= tach_i;
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            // Any return to the filtered level restarts the stability count.
            if (r_sync2 == r_filt) begin
                r_fcnt <= '0;
            end else if (clk_en_i) begin
                if (r_fcnt == c_FCNT_W'(FILTER_TICKS - 1)) begin
                    r_filt <= ~r_filt;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end
        end
    end

    assign edge_o = r_filt & ~r_filt_d;

endmodule

`default_nettype wire

// File: rtl/fan_tach_reader.sv
// ============================================================================
// Module   : fan_tach_reader
// Purpose  : Counts filtered tach rising edges over a gate window and
//            publishes a saturated speed sample with a valid strobe.
//            Stall detection is built only when FAN_TACH_STALL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fan_tach_reader
    import fan_ctrl_pkg::*;
#(
    parameter int ADC_BITWIDTH  = 8,
    parameter int WINDOW_TICKS  = 1000000,
    parameter int FILTER_TICKS  = 4,
    parameter int STALL_WINDOWS = 3
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    clk_en_i,
    input  logic                    enable_i,
    input  logic                    tach_i,
    output logic [ADC_BITWIDTH-1:0] speed_o,
    output logic                    dataValid_STRB_o,
    output logic                    stall_o,
    output logic [1:0]              state_o
);

    localparam int c_WIN_W = (clog2(WINDOW_TICKS) < 1) ? 1 : clog2(WINDOW_TICKS);
    localparam logic [ADC_BITWIDTH-1:0] c_SPEED_MAX = '1;

    logic                    w_edge;
    logic [ADC_BITWIDTH-1:0] w_edge_next;
    logic                    w_terminal;
    logic                    w_report_load;

    state_t                  r_state;
    logic [c_WIN_W-1:0]      r_win_cnt;
    logic [ADC_BITWIDTH-1:0] r_edge_cnt;
    logic [ADC_BITWIDTH-1:0] r_speed;
    logic                    r_strb;

    tach_glitch_filter #(
        .FILTER_TICKS (FILTER_TICKS)
    ) u_filter (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clk_en_i (clk_en_i),
        .tach_i   (tach_i),
        .edge_o   (w_edge)
    );

    assign w_edge_next   = (w_edge && (r_edge_cnt != c_SPEED_MAX)) ? r_edge_cnt + 1'b1
                                                                     : r_edge_cnt;
    assign w_terminal    = clk_en_i && (r_win_cnt == c_WIN_W'(WINDOW_TICKS - 1));
    assign w_report_load = enable_i && (r_state == ST_MEASURE) && w_terminal;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= ST_IDLE;
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
            r_speed    <= '0;
            r_strb     <= 1'b0;
        end else begin
            r_strb <= 1'b0;
            if (!enable_i) begin
                r_state    <= ST_IDLE;
                r_win_cnt  <= '0;
                r_edge_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state    <= ST_MEASURE;
                        r_win_cnt  <= '0;
                        r_edge_cnt <= '0;
                    end
                    ST_MEASURE: begin
                        r_edge_cnt <= w_edge_next;
                        if (w_terminal) begin
                            // An edge on the closing tick still belongs to this window.
                            r_state    <= ST_REPORT;
                            r_win_cnt  <= '0;
                            r_edge_cnt <= '0;
                            r_speed    <= w_edge_next;
                            r_strb     <= 1'b1;
                        end else if (clk_en_i) begin
                            r_win_cnt <= r_win_cnt + 1'b1;
                        end
                    end
                    ST_REPORT: begin
                        r_state    <= ST_MEASURE;
                        r_edge_cnt <= w_edge_next;
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_win_cnt  <= '0;
                        r_edge_cnt <= '0;
                    end
                endcase
            end
        end
    end

`ifdef FAN_TACH_STALL_EN
    localparam int c_STALL_W = (clog2(STALL_WINDOWS + 1) < 1) ? 1 : clog2(STALL_WINDOWS + 1);

    logic [c_STALL_W-1:0] r_stall_cnt;
    logic [c_STALL_W-1:0] w_stall_inc;
    logic                 r_stall;

    assign w_stall_inc = (r_stall_cnt == c_STALL_W'(STALL_WINDOWS)) ? r_stall_cnt
                                                                     : r_stall_cnt + 1'b1;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_stall_cnt <= '0;
            r_stall     <= 1'b0;
        end else if (!enable_i) begin
            r_stall_cnt <= '0;
            r_stall     <= 1'b0;
        end else if (w_report_load) begin
            if (w_edge_next == '0) begin
                r_stall_cnt <= w_stall_inc;
                r_stall     <= (w_stall_inc == c_STALL_W'(STALL_WINDOWS));
            end else begin
                r_stall_cnt <= '0;
                r_stall     <= 1'b0;
            end
        end
    end

    assign stall_o = r_stall;
`else
    assign stall_o = 1'b0;
`endif

    assign speed_o          = r_speed;
    assign dataValid_STRB_o = r_strb;
    assign state_o          = r_state;

endmodule

`default_nettype wire
